// File: rtl/siteswap_pkg.sv
// Shared constants, throw type and FSM state encoding for the siteswap pattern loader.
package siteswap_pkg;
  localparam int MAX_PERIOD = 7;
  localparam int MAX_THROW  = 7;

  typedef logic [2:0] throw_t;

  typedef enum logic [2:0] {
    COLLECT,
    DIVIDE,
    CHECK,
    DONE,
    ERROR
  } state_t;
endpackage

// File: rtl/siteswap_pattern_loader.sv
// Serial siteswap entry: collects throw digits, checks sum/period divisibility and landing
// collisions with repeated subtraction, then publishes pattern, ball count and period.
module siteswap_pattern_loader
  import siteswap_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] digit_in,
  input  logic       digit_valid_in,
  input  logic       commit_in,
  input  logic       clear_in,
  output logic [2:0] pattern_out [MAX_PERIOD],
  output logic [2:0] num_balls_out,
  output logic [2:0] period_out,
  output logic       pattern_valid_out,
  output logic       pattern_strobe_out,
  output logic       error_out,
  output logic       busy_out
);

  state_t     r_state;
  throw_t     r_pat [MAX_PERIOD];
  logic [2:0] r_len;
  logic [5:0] r_sum;
  logic [5:0] r_rem;
  logic [2:0] r_q;
  logic [2:0] r_i;
  logic [3:0] r_j;
  logic [6:0] r_land;

  throw_t     r_pat_out [MAX_PERIOD];
  logic [2:0] r_balls;
  logic [2:0] r_period;
  logic       r_valid;
  logic       r_strobe;
  logic       r_error;

  logic       w_dig_ok;
  logic [2:0] w_len_new;
  logic [5:0] w_sum_new;
  logic [5:0] w_len6;
  logic [2:0] w_i1;
  throw_t     w_next_throw;
  logic [3:0] w_next_j;

  assign w_dig_ok     = (digit_in <= 4'(MAX_THROW)) && (r_len < 3'(MAX_PERIOD));
  assign w_len_new    = r_len + (digit_valid_in ? 3'd1 : 3'd0);
  assign w_sum_new    = r_sum + (digit_valid_in ? {2'b00, digit_in} : 6'd0);
  assign w_len6       = {3'b000, r_len};
  assign w_i1         = r_i + 3'd1;
  // Index 7 only occurs when the last throw of a full-length pattern has landed.
  assign w_next_throw = (w_i1 == 3'(MAX_PERIOD)) ? '0 : r_pat[w_i1];
  assign w_next_j     = {1'b0, w_i1} + {1'b0, w_next_throw};

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      r_state  <= COLLECT;
      r_len    <= '0;
      r_sum    <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_land   <= '0;
      r_balls  <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
      r_error  <= 1'b0;
      for (int k = 0; k < MAX_PERIOD; k++) begin
        r_pat[k]     <= '0;
        r_pat_out[k] <= '0;
      end
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (digit_valid_in && !w_dig_ok) begin
            r_state <= ERROR;
          end else begin
            if (digit_valid_in) begin
              r_pat[r_len] <= digit_in[2:0];
              r_len        <= w_len_new;
              r_sum        <= w_sum_new;
              r_error      <= 1'b0;
              r_valid      <= 1'b0;
            end
            // A digit in the same cycle counts toward the length the commit sees.
            if (commit_in) begin
              r_rem   <= w_sum_new;
              r_q     <= '0;
              r_state <= (w_len_new == 3'd0) ? ERROR : DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (r_rem >= w_len6) begin
            r_rem <= r_rem - w_len6;
            r_q   <= r_q + 3'd1;
          end else if (r_rem != 6'd0 || r_q == 3'd0) begin
            r_state <= ERROR;
          end else begin
            r_i     <= '0;
            r_j     <= {1'b0, r_pat[0]};
            r_land  <= '0;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (r_j >= {1'b0, r_len}) begin
            r_j <= r_j - {1'b0, r_len};
          end else if (r_land[r_j[2:0]]) begin
            r_state <= ERROR;
          end else begin
            r_land[r_j[2:0]] <= 1'b1;
            r_i              <= w_i1;
            r_j              <= w_next_j;
            if (w_i1 == r_len) r_state <= DONE;
          end
        end
        DONE: begin
          for (int k = 0; k < MAX_PERIOD; k++)
            r_pat_out[k] <= (3'(k) < r_len) ? r_pat[k] : '0;
          r_balls  <= r_q;
          r_period <= r_len;
          r_valid  <= 1'b1;
          r_strobe <= 1'b1;
          r_error  <= 1'b0;
          r_len    <= '0;
          r_sum    <= '0;
          r_state  <= COLLECT;
        end
        ERROR: begin
          r_error <= 1'b1;
          r_valid <= 1'b0;
          r_len   <= '0;
          r_sum   <= '0;
          r_state <= COLLECT;
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign pattern_out        = r_pat_out;
  assign num_balls_out      = r_balls;
  assign period_out         = r_period;
  assign pattern_valid_out  = r_valid;
  assign pattern_strobe_out = r_strobe;
  assign error_out          = r_error;
  assign busy_out           = (r_state == DIVIDE) || (r_state == CHECK);

endmodule

// File: tb/tb_siteswap_pattern_loader.sv
// Randomized and directed bench for siteswap_pattern_loader against an arithmetic siteswap model.
module tb_siteswap_pattern_loader;
  import siteswap_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [3:0] digit_in = '0;
  logic       digit_valid_in = 1'b0;
  logic       commit_in = 1'b0;
  logic       clear_in = 1'b0;
  logic [2:0] pattern_out [MAX_PERIOD];
  logic [2:0] num_balls_out;
  logic [2:0] period_out;
  logic       pattern_valid_out;
  logic       pattern_strobe_out;
  logic       error_out;
  logic       busy_out;

  always #5 clk_in = ~clk_in;

  siteswap_pattern_loader dut (
    .clk_in(clk_in), .rst_in(rst_in), .digit_in(digit_in), .digit_valid_in(digit_valid_in),
    .commit_in(commit_in), .clear_in(clear_in), .pattern_out(pattern_out),
    .num_balls_out(num_balls_out), .period_out(period_out), .pattern_valid_out(pattern_valid_out),
    .pattern_strobe_out(pattern_strobe_out), .error_out(error_out), .busy_out(busy_out)
  );

  int checks = 0;
  int errors = 0;

  int exp_pat [MAX_PERIOD];
  int exp_balls, exp_period, exp_valid, exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Siteswap validity from its definition: average throw is an integer ball count > 0
  // and every throw lands on a distinct beat modulo the period.
  function automatic bit model_ok(input int d[$], output int balls);
    int n, sum, l;
    bit seen [MAX_PERIOD];
    balls = 0;
    n = d.size();
    sum = 0;
    for (int k = 0; k < MAX_PERIOD; k++) seen[k] = 1'b0;
    if (n == 0) return 1'b0;
    foreach (d[k]) sum += d[k];
    if (sum == 0 || (sum % n) != 0) return 1'b0;
    for (int k = 0; k < n; k++) begin
      l = (k + d[k]) % n;
      if (seen[l]) return 1'b0;
      seen[l] = 1'b1;
    end
    balls = sum / n;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < MAX_PERIOD; k++) exp_pat[k] = 0;
    exp_balls = 0; exp_period = 0; exp_valid = 0; exp_err = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, pattern_valid_out, exp_valid);
    chk({tag, "_error"}, error_out, exp_err);
    chk({tag, "_period"}, period_out, exp_period);
    chk({tag, "_balls"}, num_balls_out, exp_balls);
    for (int k = 0; k < MAX_PERIOD; k++)
      chk($sformatf("%s_pat%0d", tag, k), pattern_out[k], exp_pat[k]);
  endtask

  task automatic wait_done(input string tag, output bit got_strobe, output bit got_err,
                           output int cycles);
    got_strobe = 1'b0;
    got_err = 1'b0;
    cycles = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk_in); #1;
      cycles = c + 1;
      if (pattern_strobe_out) begin got_strobe = 1'b1; break; end
      if (error_out && !busy_out) begin got_err = 1'b1; break; end
    end
    if (!got_strobe && !got_err) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic run_entry(input string tag, input int d[$], input bit same);
    int n, bad, balls, cycles;
    bit ok, st, er;
    n = d.size();
    bad = -1;
    for (int k = 0; k < n; k++)
      if (d[k] > MAX_THROW || k >= MAX_PERIOD) begin bad = k; break; end
    if (bad >= 0) begin
      for (int k = 0; k <= bad; k++) begin
        @(negedge clk_in); digit_valid_in = 1'b1; digit_in = 4'(d[k]);
      end
      @(negedge clk_in); digit_valid_in = 1'b0;
      @(posedge clk_in); #1;
      exp_valid = 0; exp_err = 1;
    end else begin
      for (int k = 0; k < n; k++) begin
        @(negedge clk_in);
        digit_valid_in = 1'b1; digit_in = 4'(d[k]);
        commit_in = same && (k == n - 1);
      end
      @(negedge clk_in); digit_valid_in = 1'b0; commit_in = 1'b0;
      if (!same || n == 0) begin
        commit_in = 1'b1;
        @(negedge clk_in); commit_in = 1'b0;
      end
      wait_done(tag, st, er, cycles);
      ok = model_ok(d, balls);
      chk({tag, "_strobe"}, st, ok);
      if (ok) begin
        for (int k = 0; k < MAX_PERIOD; k++) exp_pat[k] = (k < n) ? d[k] : 0;
        exp_balls = balls; exp_period = n; exp_valid = 1; exp_err = 0;
        @(posedge clk_in); #1;
        chk({tag, "_pulse"}, pattern_strobe_out, 0);
      end else begin
        exp_valid = 0; exp_err = 1;
      end
    end
    check_outputs(tag);
    repeat (2) @(posedge clk_in);
  endtask

  // Starts a 7x7 pattern (long CHECK phase), then aborts it mid-CHECK with clear or reset.
  task automatic abort_in_check(input string tag, input bit use_rst);
    int seen_strobe, seen_err;
    for (int k = 0; k < MAX_PERIOD; k++) begin
      @(negedge clk_in); digit_valid_in = 1'b1; digit_in = 4'd7;
    end
    @(negedge clk_in); digit_valid_in = 1'b0; commit_in = 1'b1;
    @(negedge clk_in); commit_in = 1'b0;
    repeat (12) @(posedge clk_in);
    #1 chk({tag, "_busy_before"}, busy_out, 1);
    @(negedge clk_in);
    if (use_rst) rst_in = 1'b1; else clear_in = 1'b1;
    @(negedge clk_in); rst_in = 1'b0; clear_in = 1'b0;
    model_reset();
    check_outputs(tag);
    seen_strobe = 0; seen_err = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_in); #1;
      if (pattern_strobe_out) seen_strobe++;
      if (error_out || busy_out) seen_err++;
    end
    chk({tag, "_no_strobe"}, seen_strobe, 0);
    chk({tag, "_no_err_busy"}, seen_err, 0);
  endtask

  initial begin
    int q[$];
    int len, base, maxk, tmp, r, cycles, got;
    int perm [MAX_PERIOD];
    bit st, er;

    model_reset();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    check_outputs("reset");
    chk("reset_busy", busy_out, 0);
    chk("reset_strobe", pattern_strobe_out, 0);

    q = {5, 3, 1};          run_entry("p531", q, 0);
    q = {4, 4, 1};          run_entry("p441", q, 0);
    q = {4, 3, 2};          run_entry("p432_collide", q, 0);
    q = {5, 4};             run_entry("p54_mod", q, 0);
    q = {0};                run_entry("p0", q, 0);
    q = {};                 run_entry("empty", q, 0);
    q = {3, 3, 3, 3, 3, 3, 3, 3}; run_entry("over8", q, 0);
    q = {9};                run_entry("dig9", q, 0);
    q = {3};                run_entry("same3", q, 1);
    q = {5, 3, 1};          run_entry("p531b", q, 0);

    // Long pattern: busy must end within the cycle bound.
    q = {7, 7, 7, 7, 7, 7, 1};
    foreach (q[k]) begin
      @(negedge clk_in); digit_valid_in = 1'b1; digit_in = 4'(q[k]);
    end
    @(negedge clk_in); digit_valid_in = 1'b0; commit_in = 1'b1;
    @(negedge clk_in); commit_in = 1'b0;
    #1 chk("long_busy_start", busy_out, 1);
    wait_done("long", st, er, cycles);
    chk("long_bounded", (cycles < 150) ? 1 : 0, 1);
    chk("long_err", er, 1);
    exp_valid = 0; exp_err = 1;
    check_outputs("long");
    repeat (2) @(posedge clk_in);

    q = {4, 4, 1};          run_entry("p441b", q, 0);
    abort_in_check("clr", 1'b0);
    q = {4, 4, 1};          run_entry("p441c", q, 0);
    abort_in_check("rst", 1'b1);

    // Digits keyed while busy must be dropped.
    for (int k = 0; k < MAX_PERIOD; k++) begin
      @(negedge clk_in); digit_valid_in = 1'b1; digit_in = 4'd7;
    end
    @(negedge clk_in); digit_valid_in = 1'b0; commit_in = 1'b1;
    @(negedge clk_in); commit_in = 1'b0;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_in);
      digit_valid_in = busy_out; digit_in = 4'd3;
      @(posedge clk_in); #1;
      if (pattern_strobe_out) begin got = 1; break; end
    end
    @(negedge clk_in); digit_valid_in = 1'b0;
    chk("busy7_strobe", got, 1);
    for (int k = 0; k < MAX_PERIOD; k++) exp_pat[k] = 7;
    exp_balls = 7; exp_period = 7; exp_valid = 1; exp_err = 0;
    check_outputs("busy7");
    repeat (2) @(posedge clk_in);
    q = {1};                run_entry("after_busy", q, 0);

    // Random entries: half built from a permutation (always a siteswap unless all zero),
    // half raw digits that may be illegal.
    for (int it = 0; it < 40; it++) begin
      q = {};
      len = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < len; k++) perm[k] = k;
        for (int k = len - 1; k > 0; k--) begin
          r = $urandom_range(0, k);
          tmp = perm[k]; perm[k] = perm[r]; perm[r] = tmp;
        end
        for (int k = 0; k < len; k++) begin
          base = (perm[k] - k + len) % len;
          maxk = (MAX_THROW - base) / len;
          q.push_back(base + len * $urandom_range(0, maxk));
        end
      end else begin
        for (int k = 0; k < len; k++) q.push_back($urandom_range(0, 8));
      end
      run_entry($sformatf("rnd%0d", it), q, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
